// File: rtl/mem_access_pkg.sv
// Shared encodings and default geometry for the data-memory access front-end.
// Imported by the interface, the stack pointer and the access unit.
package mem_access_pkg;
   localparam int DEF_ADDR_W = 9;
   localparam int DEF_DATA_W = 16;
   localparam logic [DEF_ADDR_W-1:0] DEF_STACK_BASE  = 9'h1FF;
   localparam logic [DEF_ADDR_W-1:0] DEF_STACK_LIMIT = 9'h180;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_STORE = 2'b01,
      OP_PUSH  = 2'b10,
      OP_POP   = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_RD,
      ST_RD_WAIT,
      ST_RESP
   } state_e;
endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the memory pins of the access unit.
// master = control unit and memory side, slave = mem_access_unit.
interface mem_access_unit_if
   import mem_access_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req_valid;
   logic              req_ready;
   logic [1:0]        op;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rdata;
   logic              err;
   logic [ADDR_W-1:0] sp;
   logic              mem_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output req_valid, op, addr, wdata, mem_rdata,
      input  req_ready, rsp_valid, rdata, err, sp, mem_en, mem_addr, mem_wdata
   );

   modport slave (
      input  req_valid, op, addr, wdata, mem_rdata,
      output req_ready, rsp_valid, rdata, err, sp, mem_en, mem_addr, mem_wdata
   );
endinterface

// File: rtl/stack_pointer.sv
// Downward-growing stack pointer; sp is the next free slot, sp_inc the top entry.
// Updates one cycle after a push/pop strobe; full/empty flag illegal push/pop.
module stack_pointer
   import mem_access_pkg::*;
#(
   parameter int                ADDR_W      = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] STACK_BASE  = DEF_STACK_BASE,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              push,
   input  logic              pop,
   output logic [ADDR_W-1:0] sp,
   output logic [ADDR_W-1:0] sp_inc,
   output logic              full,
   output logic              empty
);
   always_ff @(posedge CLK) begin
      if (RST) begin
         sp <= STACK_BASE;
      end else if (push) begin
         sp <= sp - ADDR_W'(1);
      end else if (pop) begin
         sp <= sp + ADDR_W'(1);
      end
   end

   assign sp_inc = sp + ADDR_W'(1);
   // Full once sp has dropped below the lowest slot, i.e. all slots are used.
   assign full   = (sp < STACK_LIMIT);
   assign empty  = (sp == STACK_BASE);
endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding LOAD/STORE/PUSH/POP front-end for the 512x16 data memory.
// Response 2 cycles after accept for writes, 3 for reads, 1 for stack errors; req_ready only in IDLE.
module mem_access_unit
   import mem_access_pkg::*;
#(
   parameter int                ADDR_W      = DEF_ADDR_W,
   parameter int                DATA_W      = DEF_DATA_W,
   parameter logic [ADDR_W-1:0] STACK_BASE  = DEF_STACK_BASE,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = DEF_STACK_LIMIT
) (
   input  logic             CLK,
   input  logic             RST,
   mem_access_unit_if.slave bus
);
   state_e            state, state_nxt;
   op_e               op_q;
   logic [ADDR_W-1:0] eaddr_q, eaddr_nxt;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic              req_err;
   logic              accept;
   logic [ADDR_W-1:0] sp, sp_inc;
   logic              full, empty;
   logic              push, pop;

   stack_pointer #(
      .ADDR_W      (ADDR_W),
      .STACK_BASE  (STACK_BASE),
      .STACK_LIMIT (STACK_LIMIT)
   ) u_stack_pointer (
      .CLK    (CLK),
      .RST    (RST),
      .push   (push),
      .pop    (pop),
      .sp     (sp),
      .sp_inc (sp_inc),
      .full   (full),
      .empty  (empty)
   );

   assign accept = (state == ST_IDLE) && bus.req_valid;
   assign push   = (state == ST_WR) && (op_q == OP_PUSH);
   assign pop    = (state == ST_RD_WAIT) && (op_q == OP_POP);

   always_comb begin
      eaddr_nxt = bus.addr;
      req_err   = 1'b0;
      case (op_e'(bus.op))
         OP_PUSH: begin
            eaddr_nxt = sp;
            req_err   = full;
         end
         OP_POP: begin
            eaddr_nxt = sp_inc;
            req_err   = empty;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= ST_IDLE;
         op_q    <= OP_LOAD;
         eaddr_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_q    <= op_e'(bus.op);
            eaddr_q <= eaddr_nxt;
            wdata_q <= bus.wdata;
            err_q   <= req_err;
         end
         if (state == ST_RD_WAIT) begin
            rdata_q <= bus.mem_rdata;
         end
         if (state == ST_RESP) begin
            err_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      bus.err       = 1'b0;
      bus.mem_en    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      bus.rdata     = rdata_q;
      bus.sp        = sp;
      case (state)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (req_err) begin
                  state_nxt = ST_RESP;
               end else if (op_e'(bus.op) == OP_STORE || op_e'(bus.op) == OP_PUSH) begin
                  state_nxt = ST_WR;
               end else begin
                  state_nxt = ST_RD;
               end
            end
         end
         ST_WR: begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = eaddr_q;
            bus.mem_wdata = wdata_q;
            state_nxt     = ST_RESP;
         end
         ST_RD: begin
            bus.mem_addr = eaddr_q;
            state_nxt    = ST_RD_WAIT;
         end
         ST_RD_WAIT: begin
            bus.mem_addr = eaddr_q;
            state_nxt    = ST_RESP;
         end
         ST_RESP: begin
            bus.rsp_valid = 1'b1;
            bus.err       = err_q;
            state_nxt     = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end
endmodule
